// File: rtl/mux_arbiter.sv
// Round-robin arbiter that shares one registered 136-bit output stage between three
// valid/ready requesters, granting one burst at a time (capped at MAX_BURST beats).
module mux_arbiter #(
  parameter int DATA_W    = 136,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_last,
  output logic              in2_ready,
  input  logic              in3_valid,
  input  logic [DATA_W-1:0] in3_data,
  input  logic              in3_last,
  output logic              in3_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        grant_sel,
  output logic              busy
);

  // Handshake: a beat moves on a port at a rising edge exactly when that port's
  // valid and ready are both high; ready never depends on the same port's valid.

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic [3:1]        req_valid;
  logic [1:0]        pick;
  logic [1:0]        cand;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              can_load;
  logic              accept;
  logic              burst_full;
  logic              burst_end;

  assign req_valid = {in3_valid, in2_valid, in1_valid};

  // Walk the rotating order backwards so the first valid requester after ptr_q wins.
  always_comb begin
    pick = 2'd0;
    cand = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      cand = 2'(((int'(ptr_q) + i - 1) % 3) + 1);
      if (req_valid[cand]) pick = cand;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    case (grant_q)
      2'd1: begin sel_valid = in1_valid; sel_last = in1_last; sel_data = in1_data; end
      2'd2: begin sel_valid = in2_valid; sel_last = in2_last; sel_data = in2_data; end
      2'd3: begin sel_valid = in3_valid; sel_last = in3_last; sel_data = in3_data; end
      default: ;
    endcase
  end

  assign can_load   = !out_valid_q || out_ready;
  assign accept     = (state_q == XFER) && sel_valid && can_load;
  assign burst_full = (count_q == 4'(MAX_BURST - 1));
  assign burst_end  = sel_last || burst_full;

  assign in1_ready = (state_q == XFER) && (grant_q == 2'd1) && can_load;
  assign in2_ready = (state_q == XFER) && (grant_q == 2'd2) && can_load;
  assign in3_ready = (state_q == XFER) && (grant_q == 2'd3) && can_load;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    // The output register drains in either state; a load below overrides this.
    if (out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick != 2'd0) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_last_d  = burst_end;
          if (burst_end) begin
            count_d = 4'd0;
            ptr_d   = grant_q;
            grant_d = 2'd0;
            state_d = IDLE;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'd0;
      ptr_q       <= 2'd3;
      count_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant_sel = grant_q;
  assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: per-requester source queues, an expected-beat scoreboard
// with its own burst-length model, and a log of grant_sel transitions.
module tb_mux_arbiter;
  localparam int DATA_W    = 136;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:1]        src_valid;
  logic [3:1]        src_last;
  logic [DATA_W-1:0] src_data [1:3];
  logic [3:1]        src_ready;
  logic [3:1]        hold;
  logic              in1_ready, in2_ready, in3_ready;
  logic              out_valid, out_last, out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        grant_sel;
  logic              busy;

  logic [DATA_W:0]   src_q [1:3][$];
  logic [DATA_W:0]   exp_q [$];
  logic [3:1]        acc;
  logic [31:0]       gl;
  int                gl_n;
  logic [1:0]        prev_g;
  int                mdl_cnt;
  int                checks;
  int                failures;

  always #5 clk = ~clk;

  assign src_ready = {in3_ready, in2_ready, in1_ready};

  mux_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .in1_valid(src_valid[1]), .in1_data(src_data[1]), .in1_last(src_last[1]), .in1_ready(in1_ready),
    .in2_valid(src_valid[2]), .in2_data(src_data[2]), .in2_last(src_last[2]), .in2_ready(in2_ready),
    .in3_valid(src_valid[3]), .in3_data(src_data[3]), .in3_last(src_last[3]), .in3_ready(in3_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant_sel(grant_sel), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] mk(input logic [7:0] b);
    return {17{b}};
  endfunction

  // Source driver: advances each requester's queue after an accepted beat.
  initial begin
    src_valid = '0;
    src_last  = '0;
    for (int k = 1; k <= 3; k++) src_data[k] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 1; k <= 3; k++) begin
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        src_valid[k] = !rst && (src_q[k].size() > 0) && !hold[k];
        if (src_q[k].size() > 0) {src_last[k], src_data[k]} = src_q[k][0];
      end
    end
  end

  // Scoreboard: compare output beats, then record accepted input beats.
  initial begin
    logic [DATA_W:0] e;
    logic            e_last;
    acc     = '0;
    prev_g  = 2'd0;
    mdl_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc     = '0;
        prev_g  = 2'd0;
        mdl_cnt = 0;
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_beat unexpected: got last=%0b data=%h, required none", out_last, out_data);
          end else begin
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
              failures++;
              $display("FAIL out_beat: got last=%0b data=%h, required last=%0b data=%h",
                       out_last, out_data, e[DATA_W], e[DATA_W-1:0]);
            end
          end
        end
        if (grant_sel != prev_g) begin
          gl     = {gl[29:0], grant_sel};
          gl_n   = gl_n + 1;
          prev_g = grant_sel;
        end
        for (int k = 1; k <= 3; k++) begin
          acc[k] = src_valid[k] && src_ready[k];
          if (acc[k]) begin
            e_last  = src_last[k] || (mdl_cnt == MAX_BURST - 1);
            mdl_cnt = e_last ? 0 : mdl_cnt + 1;
            exp_q.push_back({e_last, src_data[k]});
          end
        end
      end
    end
  end

  task automatic clear_tb();
    for (int k = 1; k <= 3; k++) src_q[k].delete();
    exp_q.delete();
    hold = '0;
    gl   = '0;
    gl_n = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    clear_tb();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_tb();
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #2;
      if (src_q[1].size() == 0 && src_q[2].size() == 0 && src_q[3].size() == 0 &&
          exp_q.size() == 0 && !out_valid && !busy && src_valid == 3'b000) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_out_valid(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #2;
      seen = out_valid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_out_valid_timeout: got out_valid=0, required 1 within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
    if (grant_sel !== 2'd0) begin failures++; $display("FAIL rst_grant_sel: got %0d, required 0", grant_sel); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (src_ready !== 3'b000) begin failures++; $display("FAIL rst_ready: got %b, required 000", src_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    bit seen = 1'b0;
    apply_reset();
    src_q[1].push_back({1'b0, mk(8'h01)});
    src_q[1].push_back({1'b0, mk(8'h02)});
    src_q[1].push_back({1'b1, mk(8'h03)});
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #2;
      seen = src_valid[1];
    end
    checks += 2;
    if (!seen) begin failures++; $display("FAIL basic_valid_timeout: got in1_valid=0, required 1"); end
    if (grant_sel !== 2'd0) begin failures++; $display("FAIL basic_pre_grant: got %0d, required 0", grant_sel); end
    @(posedge clk);
    #2;
    checks += 3;
    if (grant_sel !== 2'd1) begin failures++; $display("FAIL basic_grant: got %0d, required 1", grant_sel); end
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b, required 1", busy); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_no_early_out: got %b, required 0", out_valid); end
    @(posedge clk);
    #2;
    checks++;
    if (!(out_valid === 1'b1 && out_data === mk(8'h01))) begin
      failures++;
      $display("FAIL basic_latency: got valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, mk(8'h01));
    end
    wait_drain(50, ok);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL basic_drain: got not idle, required idle within 50 cycles"); end
    if (grant_sel !== 2'd0) begin failures++; $display("FAIL basic_release: got %0d, required 0", grant_sel); end
    if (gl !== 32'h4 || gl_n != 2) begin failures++; $display("FAIL basic_grant_log: got %h/%0d, required 4/2", gl, gl_n); end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    for (int j = 0; j < 2; j++)
      for (int k = 1; k <= 3; k++)
        src_q[k].push_back({1'b1, mk(8'(k * 16 + j))});
    wait_drain(200, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL rr_drain: got not idle, required idle within 200 cycles"); end
    if (gl !== 32'h48C48C || gl_n != 12) begin
      failures++;
      $display("FAIL rr_grant_log: got %h/%0d, required 48c48c/12", gl, gl_n);
    end
  endtask

  task automatic test_max_burst();
    bit ok;
    bit seen = 1'b0;
    apply_reset();
    for (int i = 1; i <= 6; i++) src_q[2].push_back({i == 6, mk(8'(8'h20 + i))});
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #2;
      seen = (grant_sel == 2'd2);
    end
    src_q[1].push_back({1'b1, mk(8'hA0)});
    src_q[3].push_back({1'b1, mk(8'hB0)});
    wait_drain(200, ok);
    checks += 3;
    if (!seen) begin failures++; $display("FAIL mb_grant2_timeout: got grant_sel=%0d, required 2", grant_sel); end
    if (!ok) begin failures++; $display("FAIL mb_drain: got not idle, required idle within 200 cycles"); end
    if (gl !== 32'h8C48 || gl_n != 8) begin
      failures++;
      $display("FAIL mb_grant_log: got %h/%0d, required 8c48/8", gl, gl_n);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    for (int i = 0; i < 4; i++) src_q[1].push_back({i == 3, mk(8'(8'h40 + i))});
    wait_out_valid("bp");
    checks++;
    if (out_data !== mk(8'h40)) begin failures++; $display("FAIL bp_first: got %h, required %h", out_data, mk(8'h40)); end
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid: got %b, required 1", out_valid); end
      if (out_data !== mk(8'h40)) begin failures++; $display("FAIL bp_hold_data: got %h, required %h", out_data, mk(8'h40)); end
      if (in1_ready !== 1'b0) begin failures++; $display("FAIL bp_ready: got %b, required 0", in1_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (!(out_valid === 1'b1 && out_data === mk(8'h41))) begin
      failures++;
      $display("FAIL bp_resume: got valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, mk(8'h41));
    end
    wait_drain(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_drain: got not idle, required idle within 50 cycles"); end
  endtask

  task automatic test_drop_valid();
    bit ok;
    apply_reset();
    for (int i = 0; i < 4; i++) src_q[1].push_back({i == 3, mk(8'(8'h60 + i))});
    wait_out_valid("drop");
    hold[1] = 1'b1;
    src_q[3].push_back({1'b1, mk(8'hC0)});
    repeat (2) begin
      @(posedge clk);
      #2;
      checks += 3;
      if (grant_sel !== 2'd1) begin failures++; $display("FAIL drop_grant: got %0d, required 1", grant_sel); end
      if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy: got %b, required 1", busy); end
      if (in3_ready !== 1'b0) begin failures++; $display("FAIL drop_in3_ready: got %b, required 0", in3_ready); end
    end
    hold[1] = 1'b0;
    wait_drain(100, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL drop_drain: got not idle, required idle within 100 cycles"); end
    if (gl !== 32'h4C || gl_n != 4) begin failures++; $display("FAIL drop_grant_log: got %h/%0d, required 4c/4", gl, gl_n); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    for (int i = 0; i < 4; i++) src_q[1].push_back({i == 3, mk(8'(8'h80 + i))});
    wait_out_valid("rstmid");
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_tb();
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %b, required 0", out_valid); end
    if (grant_sel !== 2'd0) begin failures++; $display("FAIL rstmid_grant: got %0d, required 0", grant_sel); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    if (src_ready !== 3'b000) begin failures++; $display("FAIL rstmid_ready: got %b, required 000", src_ready); end
    src_q[1].push_back({1'b1, mk(8'h90)});
    src_q[2].push_back({1'b1, mk(8'hA8)});
    wait_drain(100, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL rstmid_drain: got not idle, required idle within 100 cycles"); end
    if (gl !== 32'h48 || gl_n != 4) begin failures++; $display("FAIL rstmid_grant_log: got %h/%0d, required 48/4", gl, gl_n); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    hold      = '0;
    gl        = '0;
    gl_n      = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_max_burst();
    test_backpressure();
    test_drop_valid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 136-bit mux datapath between three requesters.
- Each requester streams bursts of 136-bit beats using a valid/ready handshake.
- The block picks one requester, drives its select code, and forwards its beats through a single registered output stage with backpressure.
- Sits directly in front of the downstream 136-bit consumer and replaces the free-running mux_flag select.

Parameters:
- DATA_W, 136, width of every data bus.
- MAX_BURST, 4, maximum beats per grant; the grant is released at this count even if last has not been seen. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in1_valid  in  1  requester 1 beat valid.
- in1_data  in  DATA_W  requester 1 beat.
- in1_last  in  1  requester 1 final beat of burst.
- in1_ready  out  1  requester 1 beat accepted this cycle when high together with in1_valid.
- in2_valid / in2_data / in2_last / in2_ready: same as requester 1, for requester 2.
- in3_valid / in3_data / in3_last / in3_ready: same as requester 1, for requester 3.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DATA_W  output beat (registered).
- out_last  out  1  final beat of the forwarded burst (registered).
- out_ready  in  1  downstream accepts the output beat.
- grant_sel  out  2  granted requester: 0 = none, 1..3 = requester index (registered).
- busy  out  1  high while in the XFER state.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_last=0, grant_sel=0, busy=0, all inN_ready=0.
  - beat counter=0; FSM=IDLE.
  - Round-robin pointer set so that requester 1 has highest priority next.
  - Reset mid-burst aborts the burst and discards any held output beat; no beat is emitted afterwards.
- FSM states: IDLE, XFER.
- IDLE:
  - If any inN_valid=1 at edge N, grant the first valid requester in the rotating order that starts after the last-granted index.
  - At edge N: grant_sel is loaded, busy=1, FSM moves to XFER.
  - If no requester is valid, stay in IDLE with grant_sel=0.
  - Arbitration latency is therefore 1 cycle from valid to grant.
- XFER:
  - Combinational readiness: inK_ready = (grant_sel==K) && (!out_valid || out_ready). All other inN_ready stay 0.
  - Accepted beat (inK_valid && inK_ready) loads out_data, out_valid=1, and out_last = inK_last || (count==MAX_BURST-1). It also increments count.
  - If no beat is accepted and out_ready=1, out_valid clears to 0.
  - Burst end: the accepted beat has inK_last=1, or count reaches MAX_BURST. At that edge, count=0, the pointer is set to K, grant_sel=0, busy=0, and FSM returns to IDLE.
  - There is one mandatory idle cycle between bursts; the final beat may still be draining in the output register during it.
  - The granted requester dropping valid mid-burst: the grant is held indefinitely, with no timeout and no preemption.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last are held stable and inK_ready=0.
- Throughput: 1 beat/cycle while in XFER with out_ready held high. Input-to-output latency is 1 cycle.
- Simultaneous events on the same edge: output drain and new beat load both occur; out_valid stays 1 with the new data.
- Non-granted requesters are never dropped; their valid may stay high across any number of other grants.
- Fairness: with all three continuously valid, grant order is 1, 2, 3, 1, 2, 3, ...
- Count width: 4 bits.

Test Plan:
- Reset release, only in1 valid with a 3-beat burst (data 0x01.., 0x02.., 0x03.., last on beat 3), out_ready=1 -> grant_sel=1 one cycle after valid; out beats appear 1 cycle after each acceptance; out_last on beat 3; grant_sel returns to 0.
- All three valid with 1-beat bursts of distinct data, repeated 6 times -> grant_sel sequence 1,2,3,1,2,3 with an idle cycle between grants; out_data order matches.
- in2 streams 6 beats with no last, MAX_BURST=4 -> out_last forced on beat 4 and the grant is released; in2 is regranted only after in1/in3 if they are valid; remaining 2 beats arrive in the next grant.
- out_ready low for 3 cycles mid-burst -> out_data held constant, in ready=0 throughout, no beat lost or duplicated; streaming resumes on the first cycle out_ready=1.
- Granted requester drops valid for 2 cycles mid-burst while in3 is valid -> grant_sel unchanged, in3_ready=0; burst completes after valid returns.
- rst pulsed high during beat 2 of a 4-beat burst -> next cycle out_valid=0, grant_sel=0, all ready=0; with in1 and in2 valid, the first grant after reset goes to requester 1.
